lsu_mem_initiator: RTL
======================

// Module: lsu_mem_initiator
// PURPOSE
//  Initiator side of the byte-addressed data-memory port. Sits between the MEM stage and the data memory.
//  Accepts one load/store request per valid/ready handshake and drives address, data_in, w_enable,
//  access_size and RdUn. Memory reads are combinational and writes commit on posedge clk.
//  Misaligned halfword/word accesses are split into sequential byte accesses and the load result is reassembled.
// PARAMETERS
//  START_ADDR  32'h0100_0000  base address driven on mem_addr while idle and out of reset
// PORTS
//  clk            in   1   single clock
//  reset          in   1   asynchronous, active-high
//  req_valid      in   1   request present
//  req_ready      out  1   block can accept a request (1 only in IDLE)
//  req_we         in   1   1=store, 0=load
//  req_addr       in   32  byte address
//  req_size       in   2   BYTE/HALFWORD/WORD encoding (package)
//  req_unsigned   in   1   load zero-extends (LBU/LHU)
//  req_wdata      in   32  store data, right-justified
//  resp_valid     out  1   one-cycle completion pulse, loads and stores
//  resp_rdata     out  32  extended load data; 0 for stores
//  resp_misaligned out 1   misaligned trap flag (see CONFIGURATION)
//  mem_addr       out  32  to memory address
//  mem_wdata      out  32  to memory data_in
//  mem_we         out  1   to memory w_enable
//  mem_size       out  2   to memory access_size
//  mem_rdun       out  1   to memory RdUn
//  mem_rdata      in   32  from memory data_out, valid in the same cycle
// BEHAVIOUR
//  Reset state: IDLE. All outputs reset as follows: req_ready=1 (after reset deasserts), resp_valid=0,
//   resp_rdata=0, resp_misaligned=0, mem_addr=START_ADDR, mem_wdata=0, mem_we=0, mem_size=WORD, mem_rdun=0.
//  FSM states:
//   IDLE: takes the request when req_valid&&req_ready. Registers the request.
//    If aligned, the next state is ACCESS. If misaligned, the next state is SPLIT with byte counter k=0.
//   ACCESS: one cycle. Drives req_addr, req_size and req_unsigned directly; mem_we=req_we.
//    Captures mem_rdata at the end of the cycle. The next state is RESP.
//   SPLIT: one byte per cycle. Drives mem_addr=addr+k (32-bit wraparound), mem_size=BYTE, mem_rdun=1,
//    mem_wdata[7:0]=wdata byte k, mem_we=req_we. Byte k is placed in assembly bits [8k+7:8k].
//    After the last byte (k=1 for HALFWORD, k=3 for WORD), the next state is RESP.
//   RESP: resp_valid=1 for exactly one cycle. The next state is IDLE.
//    For split loads, resp_rdata is sign- or zero-extended from bit 15 (HALFWORD) or bit 31 (WORD).
//  Misaligned definition: HALFWORD with addr[0]=1, or WORD with addr[1:0]!=0. BYTE is never misaligned.
//  Latency, with acceptance in cycle N:
//   aligned: memory is driven in cycle N+1 and resp_valid is high in N+2.
//   split: memory is driven in N+1..N+b (b=2 or 4) and resp_valid is high in N+b+1.
//  mem_we is high only in ACCESS/SPLIT cycles of stores. In all other states mem_we=0, and the address holds its last value.
//  Out-of-range addresses are not checked here. Load data is passed through, including 32'hBADB_ADFF.
//  req_valid while busy: ignored (req_ready=0). No response backpressure; the consumer must sample resp_valid.
//  Reset during any state: immediately returns to IDLE and mem_we=0. Bytes already written by an aborted
//   split store stay written. No response is issued.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: a misaligned request goes IDLE->RESP with no memory cycle (mem_we stays 0).
//   resp_misaligned=1 and resp_rdata=0 in the RESP cycle.
//  MISALIGN_TRAP_EN undefined: misaligned requests are split as described above, and resp_misaligned is tied to 0.
// STRUCTURE
//  Package lsu_pkg: size encodings BYTE=2'b00, HALFWORD=2'b01, WORD=2'b10; FSM state encodings
//   IDLE/ACCESS/SPLIT/RESP; is_misaligned(size, addr[1:0]) function; byte-count-per-size function.
//  Sub-module lsu_load_assemble: byte-lane insertion register plus the final sign/zero extension.
// TESTING
//  Aligned LW at 0x0100_0010, memory=0xDEAD_BEEF -> mem_size=WORD for 1 cycle; resp_rdata=0xDEAD_BEEF at N+2.
//  Aligned SB 0x0000_00A5 at 0x0100_0003 -> one mem_we cycle, mem_size=BYTE, mem_wdata[7:0]=0xA5; resp_valid at N+2.
//  Split LH at 0x0100_0001, bytes 0x80 and 0xFF:
//   signed -> 4 cycles total, resp_rdata=0xFFFF_FF80; unsigned -> 0x0000_FF80.
//  Split SW 0x1122_3344 at 0x0100_0002 -> bytes 44, 33, 22, 11 at addresses +0..+3 in consecutive cycles;
//   a following LW at 0x0100_0004 returns 0x????_1122 in its low half.
//  Reset asserted in the 2nd SPLIT cycle of a word store -> mem_we drops at once; only byte 0 written;
//   no resp_valid; req_ready=1 after reset.
//  MISALIGN_TRAP_EN: LW at 0x0100_0001 -> no mem_we, resp_valid at N+1, resp_misaligned=1, resp_rdata=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the LSU data-memory initiator.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE     = 2'b00,
    HALFWORD = 2'b01,
    WORD     = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    SPLIT  = 2'b10,
    RESP   = 2'b11
  } lsu_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      HALFWORD: return a[0];
      WORD:     return a != 2'b00;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      HALFWORD: return 3'd2;
      WORD:     return 3'd4;
      default:  return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_assemble.sv
// Load-data assembly register: whole-word capture for aligned loads,
// byte-lane insertion for split loads, then final sign/zero extension.
module lsu_load_assemble
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        capture_word,
  input  logic        capture_byte,
  input  logic [1:0]  lane,
  input  logic [31:0] mem_rdata,
  input  logic        split,
  input  logic [1:0]  size,
  input  logic        zext,
  output logic [31:0] load_data
);

  logic [31:0] asm_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      asm_q <= '0;
    end else if (clear) begin
      asm_q <= '0;
    end else if (capture_word) begin
      asm_q <= mem_rdata;
    end else if (capture_byte) begin
      asm_q[{lane, 3'b000} +: 8] <= mem_rdata[7:0];
    end
  end

  // Split words are already full width; only split halfwords need extending.
  always_comb begin
    load_data = asm_q;
    if (split && size == HALFWORD) begin
      load_data = zext ? {16'h0000, asm_q[15:0]} : {{16{asm_q[15]}}, asm_q[15:0]};
    end
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Initiator for the byte-addressed data-memory port; splits misaligned accesses
// into byte accesses. Define MISALIGN_TRAP_EN to trap misaligned requests instead.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter logic [31:0] START_ADDR = 32'h0100_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic        mem_rdun,
  input  logic [31:0] mem_rdata
);

`ifdef MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  lsu_state_e  state, state_nxt;
  logic        accept, mis, trap, split_last;
  logic        we_q, uns_q, split_q, trap_q;
  logic [31:0] addr_q, wdata_q, load_data;
  logic [1:0]  size_q, k_q, k_nxt;

  assign req_ready  = (state == IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign mis        = is_misaligned(req_size, req_addr[1:0]);
  assign trap       = TRAP_EN && mis;
  assign k_nxt      = k_q + 2'd1;
  assign split_last = ({1'b0, k_q} == byte_count(size_q) - 3'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = trap ? RESP : (mis ? SPLIT : ACCESS);
      ACCESS:  state_nxt = RESP;
      SPLIT:   if (split_last) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side outputs are registered one cycle ahead of the state that
  // uses them, so they are stable for the whole ACCESS/SPLIT cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      split_q   <= 1'b0;
      trap_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= WORD;
      k_q       <= '0;
      mem_addr  <= START_ADDR;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_size  <= WORD;
      mem_rdun  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          we_q    <= req_we;
          uns_q   <= req_unsigned;
          split_q <= mis && !trap;
          trap_q  <= trap;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          size_q  <= req_size;
          k_q     <= '0;
          if (!trap) begin
            mem_addr <= req_addr;
            mem_we   <= req_we;
            if (mis) begin
              mem_size  <= BYTE;
              mem_rdun  <= 1'b1;
              mem_wdata <= {24'h0, req_wdata[7:0]};
            end else begin
              mem_size  <= req_size;
              mem_rdun  <= req_unsigned;
              mem_wdata <= req_wdata;
            end
          end
        end
        ACCESS: mem_we <= 1'b0;
        SPLIT: begin
          if (split_last) begin
            mem_we <= 1'b0;
          end else begin
            k_q       <= k_nxt;
            mem_addr  <= addr_q + {30'h0, k_q} + 32'd1;
            mem_wdata <= {24'h0, wdata_q[{k_nxt, 3'b000} +: 8]};
          end
        end
        default: ;
      endcase
    end
  end

  lsu_load_assemble u_assemble (
    .clk          (clk),
    .reset        (reset),
    .clear        (accept),
    .capture_word (state == ACCESS),
    .capture_byte (state == SPLIT),
    .lane         (k_q),
    .mem_rdata    (mem_rdata),
    .split        (split_q),
    .size         (size_q),
    .zext         (uns_q),
    .load_data    (load_data)
  );

  assign resp_valid = (state == RESP);
  assign resp_rdata = (resp_valid && !we_q && !trap_q) ? load_data : '0;

`ifdef MISALIGN_TRAP_EN
  assign resp_misaligned = resp_valid && trap_q;
`else
  assign resp_misaligned = 1'b0;
`endif

endmodule
